// File: rtl/ram512_arbiter.sv
// Round-robin arbiter and clear sequencer in front of a single-port RAM.
// Ports: clk/rst; requester A and B req/we/addr/wdata/gnt/ack; rdata;
//        clr/busy/clr_done; RAM pins ram_e/ram_w/ram_r/ram_addr/ram_din/ram_dout.
module ram512_arbiter #(
    parameter int AW     = 9,
    parameter int DW     = 16,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic          a_gnt,
    output logic          a_ack,
    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          b_gnt,
    output logic          b_ack,
    output logic [DW-1:0] rdata,
    input  logic          clr,
    output logic          busy,
    output logic          clr_done,
    output logic          ram_e,
    output logic          ram_w,
    output logic          ram_r,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ACCESS  = 3'd1;
    localparam logic [2:0] S_WAIT_RD = 3'd2;
    localparam logic [2:0] S_DONE    = 3'd3;
    localparam logic [2:0] S_CLEAR   = 3'd4;

    localparam logic [1:0] LAST_W = 2'(RD_LAT - 1);

    logic [2:0]    state_q, state_d;
    logic          last_b_q, last_b_d;
    logic          clr_pend_q, clr_pend_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [1:0]    wcnt_q, wcnt_d;
    logic [AW-1:0] cnt_q, cnt_d;

    logic          a_gnt_q, a_gnt_d;
    logic          b_gnt_q, b_gnt_d;
    logic          a_ack_q, a_ack_d;
    logic          b_ack_q, b_ack_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          busy_q, busy_d;
    logic          clr_done_q, clr_done_d;
    logic          ram_e_q, ram_e_d;
    logic          ram_w_q, ram_w_d;
    logic          ram_r_q, ram_r_d;
    logic [AW-1:0] ram_addr_q, ram_addr_d;
    logic [DW-1:0] ram_din_q, ram_din_d;

    logic          pick_b;

    // RAM pins are registered from the next state, so the strobes line up
    // with the cycle the FSM spends in ACCESS or CLEAR.
    always_comb begin
        state_d    = state_q;
        last_b_d   = last_b_q;
        clr_pend_d = clr_pend_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wcnt_d     = wcnt_q;
        cnt_d      = cnt_q;
        rdata_d    = rdata_q;
        a_gnt_d    = 1'b0;
        b_gnt_d    = 1'b0;
        a_ack_d    = 1'b0;
        b_ack_d    = 1'b0;
        clr_done_d = 1'b0;
        ram_w_d    = 1'b0;
        ram_r_d    = 1'b0;
        ram_addr_d = '0;
        ram_din_d  = '0;
        pick_b     = 1'b0;

        if (clr && state_q != S_IDLE && state_q != S_CLEAR) begin
            clr_pend_d = 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (clr || clr_pend_q) begin
                    state_d    = S_CLEAR;
                    clr_pend_d = 1'b0;
                    cnt_d      = '0;
                    ram_w_d    = 1'b1;
                    ram_addr_d = '0;
                end else if (a_req || b_req) begin
                    // B wins only alone or when A was served last.
                    pick_b     = b_req && (!a_req || !last_b_q);
                    last_b_d   = pick_b;
                    a_gnt_d    = !pick_b;
                    b_gnt_d    = pick_b;
                    we_d       = pick_b ? b_we    : a_we;
                    addr_d     = pick_b ? b_addr  : a_addr;
                    wdata_d    = pick_b ? b_wdata : a_wdata;
                    state_d    = S_ACCESS;
                    ram_addr_d = addr_d;
                    ram_w_d    = we_d;
                    ram_r_d    = !we_d;
                    ram_din_d  = we_d ? wdata_d : '0;
                end
            end
            S_ACCESS: begin
                if (we_q) begin
                    state_d = S_DONE;
                    a_ack_d = !last_b_q;
                    b_ack_d = last_b_q;
                end else begin
                    state_d = S_WAIT_RD;
                    wcnt_d  = '0;
                end
            end
            S_WAIT_RD: begin
                if (wcnt_q == LAST_W) begin
                    rdata_d = ram_dout;
                    state_d = S_DONE;
                    a_ack_d = !last_b_q;
                    b_ack_d = last_b_q;
                end else begin
                    wcnt_d = wcnt_q + 2'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            S_CLEAR: begin
                if (cnt_q == '1) begin
                    state_d    = S_IDLE;
                    clr_done_d = 1'b1;
                end else begin
                    cnt_d      = cnt_q + 1'b1;
                    ram_w_d    = 1'b1;
                    ram_addr_d = cnt_d;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d  = (state_d != S_IDLE);
        ram_e_d = ram_w_d | ram_r_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            last_b_q   <= 1'b1;
            clr_pend_q <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wcnt_q     <= '0;
            cnt_q      <= '0;
            a_gnt_q    <= 1'b0;
            b_gnt_q    <= 1'b0;
            a_ack_q    <= 1'b0;
            b_ack_q    <= 1'b0;
            rdata_q    <= '0;
            busy_q     <= 1'b0;
            clr_done_q <= 1'b0;
            ram_e_q    <= 1'b0;
            ram_w_q    <= 1'b0;
            ram_r_q    <= 1'b0;
            ram_addr_q <= '0;
            ram_din_q  <= '0;
        end else begin
            state_q    <= state_d;
            last_b_q   <= last_b_d;
            clr_pend_q <= clr_pend_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wcnt_q     <= wcnt_d;
            cnt_q      <= cnt_d;
            a_gnt_q    <= a_gnt_d;
            b_gnt_q    <= b_gnt_d;
            a_ack_q    <= a_ack_d;
            b_ack_q    <= b_ack_d;
            rdata_q    <= rdata_d;
            busy_q     <= busy_d;
            clr_done_q <= clr_done_d;
            ram_e_q    <= ram_e_d;
            ram_w_q    <= ram_w_d;
            ram_r_q    <= ram_r_d;
            ram_addr_q <= ram_addr_d;
            ram_din_q  <= ram_din_d;
        end
    end

    assign a_gnt    = a_gnt_q;
    assign b_gnt    = b_gnt_q;
    assign a_ack    = a_ack_q;
    assign b_ack    = b_ack_q;
    assign rdata    = rdata_q;
    assign busy     = busy_q;
    assign clr_done = clr_done_q;
    assign ram_e    = ram_e_q;
    assign ram_w    = ram_w_q;
    assign ram_r    = ram_r_q;
    assign ram_addr = ram_addr_q;
    assign ram_din  = ram_din_q;

endmodule

// File: doc/ram512_arbiter.md
Name: ram512_arbiter

Overview:
- Two-port round-robin arbiter and sequencer in front of a single-port RAM512 (9-bit address, 16-bit data, e/w/r strobes).
- Lets two requesters (A, B) share the RAM: one access at a time, with a req/gnt/ack handshake.
- Adds a built-in clear sequencer that zero-fills every word of the RAM.
- Sits between the client blocks and the RAM512 instance; the only block that drives the RAM pins.

Parameters:
AW, 9, RAM address width; depth = 2**AW
DW, 16, RAM data width
RD_LAT, 1, cycles from the ram_r strobe cycle until ram_dout is valid (1..3)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous active-high reset
a_req  in  1  requester A access request (level)
a_we  in  1  A: 1=write, 0=read
a_addr  in  AW  A address
a_wdata  in  DW  A write data
a_gnt  out  1  one-cycle pulse, A's command latched
a_ack  out  1  one-cycle pulse, A's access complete
b_req, b_we, b_addr, b_wdata, b_gnt, b_ack  same as A, for requester B
rdata  out  DW  read data of the last completed read; valid while ack is high and held afterwards
clr  in  1  pulse, request a full zero-fill
busy  out  1  high whenever the FSM is not in IDLE
clr_done  out  1  one-cycle pulse after the last clear write
ram_e  out  1  RAM enable
ram_w  out  1  RAM write strobe
ram_r  out  1  RAM read strobe
ram_addr  out  AW  RAM address
ram_din  out  DW  RAM write data
ram_dout  in  DW  RAM read data

Behaviour:
- Reset: all outputs 0; FSM to IDLE; clr_pend=0; last_grant=B, so A wins the first tie. Reset mid-access or mid-clear aborts with no ack or clr_done. Reset wins over every other input.
- All outputs are registered. ram_e=1 only when ram_w or ram_r is 1.
- FSM states: IDLE, ACCESS, WAIT_RD, DONE, CLEAR.
- IDLE priority:
  - clr or clr_pend -> CLEAR; clear counter=0; clr_pend<=0.
  - Otherwise a single request -> that requester.
  - Both requesting -> the requester that is not last_grant.
  - On grant: latch we/addr/wdata; pulse gnt for 1 cycle; update last_grant; -> ACCESS.
- ACCESS (1 cycle): drive ram_addr. For a write, ram_w=1 and ram_din=wdata, then -> DONE. For a read, ram_r=1, then -> WAIT_RD.
- WAIT_RD: lasts RD_LAT cycles. On the final edge, capture ram_dout into rdata, then -> DONE.
- DONE (1 cycle): ack high for the granted requester only, then -> IDLE unconditionally.
- Requester protocol:
  - Hold req, we, addr and wdata stable from req until ack.
  - Drop req in the cycle after ack, or it is treated as a new request.
  - req is sampled only in IDLE.
- Latency from req high (IDLE) to ack high: write = 2 cycles; read = 2+RD_LAT cycles.
- CLEAR: one write per cycle, ram_w=1, ram_din=0, ram_addr=counter 0..2**AW-1. After the last address, pulse clr_done and -> IDLE. No requester is granted during CLEAR.
- clr seen in any non-IDLE state sets clr_pend; the clear runs at the next IDLE, ahead of pending requests. clr while already in CLEAR is ignored and does not restart the sweep.
- Fairness: with both req held continuously, grants alternate A, B, A, ...
- Counters and addresses wrap at 2**AW without overflow flags. Requester addresses are used as-is.

Test Plan:
- Reset then A writes 0x1234 to addr 5 -> a_gnt at cycle+1; ram_w=1 with addr 5 and din 0x1234 at cycle+1; a_ack at cycle+2; b_gnt and b_ack never assert.
- After that write, B reads addr 5 (RD_LAT=1) -> ram_r at cycle+1; b_ack at cycle+3; rdata=0x1234.
- A and B request in the same cycle right after reset -> A granted first, then B. With both held for 4 accesses, grant order is A, B, A, B.
- Write i to addr 2*i for i=0..63, then read all 64 back -> each rdata equals i; busy is low only in IDLE cycles.
- clr asserted during an A read -> the A read completes with its ack. Then exactly 512 consecutive ram_w cycles with din=0 on addresses 0..511, then clr_done. A pending B req is granted only after clr_done. Read of addr 10 afterwards -> 0.
- rst asserted in the middle of CLEAR (address 100) -> next cycle all outputs 0 and no clr_done. A new A request after reset is served normally.
